// File: rtl/jt51_pg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : jt51_pg_sched
//  Purpose  : Phase-generator slot scheduler. Walks 32 operator slots, holds
//             the per-channel/per-slot PG register file written by the host,
//             and presents each slot's parameters at its pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
module jt51_pg_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       zero,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [2:0] pms_I,
    output logic [1:0] dt2_I,
    output logic [2:0] dt1_II,
    output logic       pg_rst_III,
    output logic [3:0] mul_VI
);

    logic [4:0]  r_cnt;
    logic [6:0]  r_kc    [8];
    logic [5:0]  r_kf    [8];
    logic [2:0]  r_pms   [8];
    logic [3:0]  r_keyon [8];
    logic [2:0]  r_dt1   [32];
    logic [3:0]  r_mul   [32];
    logic [1:0]  r_dt2   [32];
    logic [31:0] r_pending;
    logic        r_blocked;

    logic [4:0]  w_cnt_nx;
    logic [4:0]  w_slot_ii;
    logic [4:0]  w_slot_iii;
    logic [4:0]  w_slot_vi;
    logic        w_commit;
    logic [2:0]  w_kon_ch;
    logic [3:0]  w_kon_new;
    logic [3:0]  w_kon_rise;
    logic [31:0] w_pend_set;
    logic [31:0] w_pend_clr;

    // Outputs are loaded with the slot the counter is about to reach, so the
    // later stages simply look a fixed number of slots behind.
    assign w_cnt_nx   = r_cnt + 5'd1;
    assign w_slot_ii  = w_cnt_nx - 5'd1;
    assign w_slot_iii = w_cnt_nx - 5'd2;
    assign w_slot_vi  = w_cnt_nx - 5'd5;

    // A held request commits once; it must drop before the next one counts.
    assign w_commit   = cen & wr_req & ~r_blocked;
    assign w_kon_ch   = wr_data[2:0];
    assign w_kon_new  = wr_data[6:3];
    assign w_kon_rise = w_kon_new & ~r_keyon[w_kon_ch];

    // Pending set/clear masks; a set in the same cycle as a clear wins.
    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (w_commit && wr_addr == 8'h08) begin
            for (int op = 0; op < 4; op++) begin
                if (w_kon_rise[op]) w_pend_set[op*8 + int'(w_kon_ch)] = 1'b1;
            end
        end
        if (cen) w_pend_clr[w_slot_iii] = 1'b1;
    end

    // Slot counter.
    always_ff @(posedge clk) begin
        if (!rst_n)   r_cnt <= '0;
        else if (cen) r_cnt <= w_cnt_nx;
    end

    // Host write handshake: one-cycle ack after commit, re-arm on wr_req low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            wr_ack <= w_commit;
            if (w_commit)     r_blocked <= 1'b1;
            else if (!wr_req) r_blocked <= 1'b0;
        end
    end

    // Register file writes; unmapped addresses are acknowledged and dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_kc[i]    <= '0;
                r_kf[i]    <= '0;
                r_pms[i]   <= '0;
                r_keyon[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                r_dt1[i] <= '0;
                r_mul[i] <= '0;
                r_dt2[i] <= '0;
            end
        end else if (w_commit) begin
            casez (wr_addr)
                8'h08:       r_keyon[w_kon_ch]    <= w_kon_new;
                8'b0010_1???: r_kc[wr_addr[2:0]]  <= wr_data[6:0];
                8'b0011_0???: r_kf[wr_addr[2:0]]  <= wr_data[7:2];
                8'b0011_1???: r_pms[wr_addr[2:0]] <= wr_data[6:4];
                8'b010?_????: begin
                    r_dt1[wr_addr[4:0]] <= wr_data[6:4];
                    r_mul[wr_addr[4:0]] <= wr_data[3:0];
                end
                8'b110?_????: r_dt2[wr_addr[4:0]] <= wr_data[7:6];
                default: ;
            endcase
        end
    end

    // Pending phase-reset flags, one per slot.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
    end

    // Staged slot outputs, loaded on each enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero       <= 1'b1;
            kc_I       <= '0;
            kf_I       <= '0;
            pms_I      <= '0;
            dt2_I      <= '0;
            dt1_II     <= '0;
            pg_rst_III <= 1'b0;
            mul_VI     <= '0;
        end else if (cen) begin
            zero       <= (w_cnt_nx == 5'd0);
            kc_I       <= r_kc[w_cnt_nx[2:0]];
            kf_I       <= r_kf[w_cnt_nx[2:0]];
            pms_I      <= r_pms[w_cnt_nx[2:0]];
            dt2_I      <= r_dt2[w_cnt_nx];
            dt1_II     <= r_dt1[w_slot_ii];
            pg_rst_III <= r_pending[w_slot_iii];
            mul_VI     <= r_mul[w_slot_vi];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt51_pg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt51_pg_sched
//  Purpose  : Directed vector bench for jt51_pg_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt51_pg_sched;

    logic       clk = 1'b0;
    logic       rst_n, cen, wr_req;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack, zero, pg_rst_III;
    logic [6:0] kc_I;
    logic [5:0] kf_I;
    logic [2:0] pms_I, dt1_II;
    logic [1:0] dt2_I;
    logic [3:0] mul_VI;

    int n_cmp = 0;
    int n_bad = 0;
    int bcnt  = 0;

    typedef struct {
        int         n;
        logic [6:0] kc;
        logic [5:0] kf;
        logic [2:0] pms;
        logic [1:0] dt2;
        logic [2:0] dt1;
        logic [3:0] mul;
    } vec_t;
    vec_t tbl[6];

    jt51_pg_sched dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .zero(zero),
        .kc_I(kc_I), .kf_I(kf_I), .pms_I(pms_I), .dt2_I(dt2_I),
        .dt1_II(dt1_II), .pg_rst_III(pg_rst_III), .mul_VI(mul_VI)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the bench tracks the expected slot counter itself.
    task automatic tick();
        @(posedge clk);
        if (!rst_n)   bcnt = 0;
        else if (cen) bcnt = (bcnt + 1) % 32;
        #1;
    endtask

    function automatic logic data_nz();
        return ({kc_I, kf_I, pms_I, dt2_I, dt1_II, mul_VI} != '0);
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        int k = 0;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        while (wr_ack !== 1'b1 && k < 20) begin tick(); k++; end
        chk("wr_ack_seen", {31'b0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        tick();
        chk("wr_ack_single", {31'b0, wr_ack}, 32'd0);
    endtask

    task automatic run_to(input int n);
        int k = 0;
        while (bcnt != n && k < 40) begin tick(); k++; end
        if (k >= 40) chk("run_to_timeout", 32'd1, 32'd0);
    endtask

    task automatic watch(input int ncyc, output int pulses, output int at);
        pulses = 0; at = -1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (pg_rst_III === 1'b1) begin pulses++; at = bcnt; end
        end
    endtask

    // One full pass after reset: zero only at slot 0, no data, no phase reset.
    task automatic idle_pass(input int ncyc, input int exp_zeros);
        int zc = 0, zerr = 0, derr = 0, perr = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (zero !== (bcnt == 0)) zerr++;
            if (zero === 1'b1) zc++;
            if (data_nz()) derr++;
            if (pg_rst_III !== 1'b0) perr++;
        end
        chk("idle_zero_count", zc, exp_zeros);
        chk("idle_zero_align", zerr, 0);
        chk("idle_data_zero", derr, 0);
        chk("idle_no_pgrst", perr, 0);
    endtask

    initial begin
        int p, at, acks;
        tbl[0] = '{3,  7'h4A, 6'h21, 3'd5, 2'd0, 3'd0, 4'd0};
        tbl[1] = '{4,  7'h00, 6'h00, 3'd0, 2'd0, 3'd0, 4'd0};
        tbl[2] = '{6,  7'h00, 6'h00, 3'd0, 2'd0, 3'd3, 4'd0};
        tbl[3] = '{10, 7'h00, 6'h00, 3'd0, 2'd0, 3'd0, 4'd7};
        tbl[4] = '{11, 7'h4A, 6'h21, 3'd5, 2'd2, 3'd0, 4'd0};
        tbl[5] = '{19, 7'h4A, 6'h21, 3'd5, 2'd0, 3'd0, 4'd0};

        rst_n = 1'b0; cen = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_data", {31'b0, data_nz()}, 32'd0);
        chk("rst_ack", {31'b0, wr_ack}, 32'd0);
        chk("rst_pgrst", {31'b0, pg_rst_III}, 32'd0);

        // Released but no cen yet: reset values hold.
        rst_n = 1'b1; cen = 1'b0;
        tick(); tick(); tick();
        chk("nocen_zero", {31'b0, zero}, 32'd1);
        chk("nocen_data", {31'b0, data_nz()}, 32'd0);

        cen = 1'b1;
        idle_pass(64, 2);

        // Program the register file (last write is unmapped and discarded).
        wr(8'h2B, 8'h4A);
        wr(8'h45, 8'h37);
        wr(8'h33, 8'h84);
        wr(8'h3B, 8'h50);
        wr(8'hCB, 8'h80);
        wr(8'h10, 8'hFF);

        foreach (tbl[i]) begin
            run_to(tbl[i].n);
            chk($sformatf("kc_I@%0d", tbl[i].n),   kc_I,   tbl[i].kc);
            chk($sformatf("kf_I@%0d", tbl[i].n),   kf_I,   tbl[i].kf);
            chk($sformatf("pms_I@%0d", tbl[i].n),  pms_I,  tbl[i].pms);
            chk($sformatf("dt2_I@%0d", tbl[i].n),  dt2_I,  tbl[i].dt2);
            chk($sformatf("dt1_II@%0d", tbl[i].n), dt1_II, tbl[i].dt1);
            chk($sformatf("mul_VI@%0d", tbl[i].n), mul_VI, tbl[i].mul);
        end

        // cen low: everything holds.
        run_to(3);
        cen = 1'b0;
        tick(); tick(); tick();
        chk("hold_kc", kc_I, 7'h4A);
        chk("hold_zero", {31'b0, zero}, 32'd0);
        cen = 1'b1;
        tick();
        chk("resume_kc", kc_I, 7'h00);

        // Key-on ch2 op0 -> single phase reset at slot 2 in stage III (cnt 4).
        run_to(10);
        wr(8'h08, 8'h0A);
        watch(40, p, at);
        chk("kon_pulses", p, 1);
        chk("kon_at", at, 4);
        run_to(10);
        wr(8'h08, 8'h0A);
        watch(40, p, at);
        chk("kon_repeat_pulses", p, 0);
        run_to(10);
        wr(8'h08, 8'h02);
        wr(8'h08, 8'h0A);
        watch(40, p, at);
        chk("kon_rekey_pulses", p, 1);
        chk("kon_rekey_at", at, 4);

        // Request held 10 cycles while cen toggles: one commit, one ack.
        run_to(10);
        wr_addr = 8'h2C; wr_data = 8'h11; wr_req = 1'b1; acks = 0;
        for (int i = 0; i < 10; i++) begin
            cen = (i % 2 == 1);
            tick();
            if (wr_ack === 1'b1) acks++;
        end
        wr_req = 1'b0; cen = 1'b1;
        tick();
        chk("held_req_acks", acks, 1);
        run_to(4);
        chk("held_req_kc", kc_I, 7'h11);

        // Rising key-on committed exactly when slot 2's pending clears.
        run_to(10);
        wr(8'h08, 8'h02);
        wr(8'h08, 8'h0A);
        wr(8'h08, 8'h02);
        run_to(3);
        wr_addr = 8'h08; wr_data = 8'h0A; wr_req = 1'b1;
        tick();
        chk("race_pulse1", {31'b0, pg_rst_III}, 32'd1);
        chk("race_ack", {31'b0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        watch(40, p, at);
        chk("race_second_pulses", p, 1);
        chk("race_second_at", at, 4);

        // Mid-pass reset with a write in flight: all cleared, write dropped.
        run_to(7);
        rst_n = 1'b0; wr_addr = 8'h2D; wr_data = 8'h55; wr_req = 1'b1;
        tick();
        chk("mrst_zero", {31'b0, zero}, 32'd1);
        chk("mrst_data", {31'b0, data_nz()}, 32'd0);
        chk("mrst_ack", {31'b0, wr_ack}, 32'd0);
        rst_n = 1'b1; wr_req = 1'b0;
        tick();
        chk("mrst_cnt1_zero", {31'b0, zero}, 32'd0);
        chk("mrst_ack_after", {31'b0, wr_ack}, 32'd0);
        idle_pass(32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt51_pg_sched.md
JT51_PG_SCHED -- requirements
Module: jt51_pg_sched

Interface
REQ-001 SHALL have no parameters; slot count fixed at 32 (8 channels x 4 operators), slot index = {op[1:0], ch[2:0]}.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cen  input  1  clock enable; all state advances only when cen=1, except reset.
REQ-005 wr_req  input  1  host write request; held high until wr_ack.
REQ-006 wr_addr  input  8  register address.
REQ-007 wr_data  input  8  register data.
REQ-008 wr_ack  output  1  one-cycle pulse: write committed.
REQ-009 zero  output  1  high while slot counter = 0.
REQ-010 kc_I  output  7  key code for the slot in PG stage I.
REQ-011 kf_I  output  6  key fraction, stage I.
REQ-012 pms_I  output  3  PM sensitivity, stage I.
REQ-013 dt2_I  output  2  coarse detune, stage I.
REQ-014 dt1_II  output  3  fine detune for the slot in stage II.
REQ-015 pg_rst_III  output  1  phase reset for the slot in stage III.
REQ-016 mul_VI  output  4  multiplier for the slot in stage VI.

Function
REQ-017 5-bit slot counter cnt SHALL increment by 1 on each cen cycle, wrapping 31->0.
REQ-018 Register file SHALL hold per channel: kc[6:0], kf[5:0], pms[2:0], keyon[3:0] (one bit per op); per slot: dt1[2:0], mul[3:0], dt2[1:0].
REQ-019 Address map: 0x08 key-on (data[2:0]=ch, data[6:3]=op mask, bit 3+op); 0x28-0x2F kc=data[6:0]; 0x30-0x37 kf=data[7:2]; 0x38-0x3F pms=data[6:4]; 0x40-0x5F dt1=data[6:4], mul=data[3:0], slot=addr[4:0]; 0xC0-0xDF dt2=data[7:6], slot=addr[4:0]; channel = addr[2:0] where applicable.
REQ-020 Writes to other addresses SHALL be acknowledged and discarded.
REQ-021 A write with wr_req=1 SHALL commit on the first cen cycle at or after wr_req rises; wr_ack SHALL pulse high in the cycle following that commit; wr_ack SHALL be 0 otherwise.
REQ-022 After wr_ack, a new write SHALL be accepted only when wr_req has been low for at least one cycle (no double commit of a held request).
REQ-023 Outputs SHALL be registered on cen; after the cen cycle where cnt becomes N: kc_I/kf_I/pms_I/dt2_I reflect slot N, dt1_II slot N-1, pg_rst_III slot N-2, mul_VI slot N-5, all mod 32.
REQ-024 Register values committed in cycle t SHALL be visible on outputs for any slot read after t; no bypass into the same cycle's output.
REQ-025 A 0->1 transition of keyon bit for (ch,op) SHALL set pending[slot]; 1->0 or 1->1 SHALL not change pending.
REQ-026 pg_rst_III SHALL be 1 for exactly one pass when its slot has pending=1, and that pending bit SHALL clear in the same cycle.
REQ-027 Simultaneous set and clear of the same pending bit SHALL leave it set (reset issued again next pass).
REQ-028 zero SHALL be registered and equal (cnt==0) after each cen cycle.
REQ-029 With cen=0 all outputs and state SHALL hold; wr_ack SHALL not pulse.

Reset
REQ-030 On rst_n=0 at a clk edge (regardless of cen): cnt=0, all register-file entries=0, pending=0, internal ack/edge state cleared.
REQ-031 During and after reset until the first cen: wr_ack=0, zero=1, kc_I=kf_I=pms_I=dt2_I=dt1_II=mul_VI=0, pg_rst_III=0.
REQ-032 A write in progress when reset asserts SHALL be dropped without wr_ack; host must re-issue.

Verification
REQ-033 Reset, cen=1 for 64 cycles -> zero high exactly once per 32 cycles, all data outputs 0, pg_rst_III never 1.
REQ-034 Write 0x2B=0x4A, 0x45=0x37 (slot 5 = op0 ch5: dt1=3, mul=7) -> wr_ack one cycle each; kc_I=0x4A when slot 3 in stage I; dt1_II=3 when slot 5 in stage II; mul_VI=7 when slot 5 in stage VI.
REQ-035 Write 0x08=0x0A (ch2, op0) -> pg_rst_III=1 exactly once, when slot 2 in stage III; rewriting 0x0A -> no further pulse; write 0x02 then 0x0A -> one new pulse.
REQ-036 wr_req held high 10 cycles with cen toggling 1/0 -> exactly one commit and one wr_ack.
REQ-037 Key-on rising edge committed in the same cycle slot's pending clears -> pg_rst_III pulses on two consecutive passes of that slot.
REQ-038 rst_n low for 1 cycle mid-pass after programming regs -> all outputs 0, regfile reads back 0, cnt restarts at 0.
